// File: rtl/writeback_pipe_pkg.sv
// Shared core constants for the EX->MEM->WB writeback path.
package writeback_pipe_pkg;
   localparam int XLEN_DEF  = 32;
   localparam int REG_AW    = 5;
   localparam int CNT_W_DEF = 16;

   function automatic logic is_x0(input logic [REG_AW-1:0] rd);
      return (rd == '0);
   endfunction
endpackage

// File: rtl/pipe_stage_reg.sv
// Enable-gated pipeline register with asynchronous active-low clear.
module pipe_stage_reg #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         q <= '0;
      else if (en)
         q <= d;
   end
endmodule

// File: rtl/writeback_pipe.sv
// EX/MEM and MEM/WB stage registers, register-file write port,
// load-use hazard detect and a saturating stall-cycle counter.
module writeback_pipe
   import writeback_pipe_pkg::*;
#(
   parameter int XLEN  = XLEN_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ex_valid,
   input  logic [4:0]        ex_rd,
   input  logic              ex_reg_write,
   input  logic              ex_mem_read,
   input  logic [XLEN-1:0]   ex_result,
   input  logic [XLEN-1:0]   mem_rdata,
   input  logic              hold,
   input  logic [4:0]        id_rs1,
   input  logic [4:0]        id_rs2,
   input  logic              id_use_rs1,
   input  logic              id_use_rs2,
   input  logic              cnt_clr,
   output logic [4:0]        mem_rd,
   output logic              mem_reg_write,
   output logic [XLEN-1:0]   mem_result,
   output logic [4:0]        wb_rd,
   output logic              wb_reg_write,
   output logic [XLEN-1:0]   wb_data,
   output logic              rf_we,
   output logic [4:0]        rf_waddr,
   output logic [XLEN-1:0]   rf_wdata,
   output logic              load_use_stall,
   output logic [CNT_W-1:0]  stall_cnt
);
   localparam int CTL_W = REG_AW + 2;

   logic              adv;
   logic              mem_is_load;
   logic [CTL_W-1:0]  ex_ctl_d;
   logic [CTL_W-1:0]  mem_ctl_q;
   logic [REG_AW:0]   wb_ctl_q;
   logic [XLEN-1:0]   wb_data_d;
   logic              ex_load_hit;

   assign adv = !hold;

   // A bubble forces rd to 0 so no stale address leaks into the bypass network.
   assign ex_ctl_d = {(ex_valid ? ex_rd : 5'd0),
                      ex_valid & ex_reg_write & !is_x0(ex_rd),
                      ex_valid & ex_mem_read};

   pipe_stage_reg #(.W(CTL_W)) u_exmem_ctl (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (adv),
      .d     (ex_ctl_d),
      .q     (mem_ctl_q)
   );

   assign {mem_rd, mem_reg_write, mem_is_load} = mem_ctl_q;

   pipe_stage_reg #(.W(XLEN)) u_exmem_data (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (adv & ex_valid & ex_reg_write),
      .d     (ex_result),
      .q     (mem_result)
   );

   pipe_stage_reg #(.W(REG_AW+1)) u_memwb_ctl (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (adv),
      .d     ({mem_rd, mem_reg_write}),
      .q     (wb_ctl_q)
   );

   assign {wb_rd, wb_reg_write} = wb_ctl_q;
   assign wb_data_d = mem_is_load ? mem_rdata : mem_result;

   pipe_stage_reg #(.W(XLEN)) u_memwb_data (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (adv & mem_reg_write),
      .d     (wb_data_d),
      .q     (wb_data)
   );

   // Rewriting the same value while held is harmless, so no hold gating here.
   assign rf_we    = wb_reg_write;
   assign rf_waddr = wb_rd;
   assign rf_wdata = wb_data;

   assign ex_load_hit    = ex_valid & ex_mem_read & ex_reg_write & !is_x0(ex_rd);
   assign load_use_stall = ex_load_hit &
                           ((id_use_rs1 & (id_rs1 == ex_rd)) |
                            (id_use_rs2 & (id_rs2 == ex_rd)));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         stall_cnt <= '0;
      else if (cnt_clr)
         stall_cnt <= '0;
      else if ((load_use_stall | hold) && (stall_cnt != {CNT_W{1'b1}}))
         stall_cnt <= stall_cnt + 1'b1;
   end
endmodule

// File: tb/tb_writeback_pipe.sv
// Directed checks of writeback_pipe: latency, load-use detect, hold, x0, counter, reset.
module tb_writeback_pipe;
   localparam int XLEN  = 32;
   localparam int CNT_W = 16;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              ex_valid, ex_reg_write, ex_mem_read, hold, cnt_clr;
   logic [4:0]        ex_rd, id_rs1, id_rs2;
   logic              id_use_rs1, id_use_rs2;
   logic [XLEN-1:0]   ex_result, mem_rdata;
   logic [4:0]        mem_rd, wb_rd, rf_waddr;
   logic              mem_reg_write, wb_reg_write, rf_we, load_use_stall;
   logic [XLEN-1:0]   mem_result, wb_data, rf_wdata;
   logic [CNT_W-1:0]  stall_cnt;

   int n_chk = 0;
   int n_err = 0;

   writeback_pipe #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .ex_valid       (ex_valid),
      .ex_rd          (ex_rd),
      .ex_reg_write   (ex_reg_write),
      .ex_mem_read    (ex_mem_read),
      .ex_result      (ex_result),
      .mem_rdata      (mem_rdata),
      .hold           (hold),
      .id_rs1         (id_rs1),
      .id_rs2         (id_rs2),
      .id_use_rs1     (id_use_rs1),
      .id_use_rs2     (id_use_rs2),
      .cnt_clr        (cnt_clr),
      .mem_rd         (mem_rd),
      .mem_reg_write  (mem_reg_write),
      .mem_result     (mem_result),
      .wb_rd          (wb_rd),
      .wb_reg_write   (wb_reg_write),
      .wb_data        (wb_data),
      .rf_we          (rf_we),
      .rf_waddr       (rf_waddr),
      .rf_wdata       (rf_wdata),
      .load_use_stall (load_use_stall),
      .stall_cnt      (stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic set_ex(input logic v, input logic [4:0] rd, input logic rw,
                         input logic ld, input logic [XLEN-1:0] res);
      ex_valid     = v;
      ex_rd        = rd;
      ex_reg_write = rw;
      ex_mem_read  = ld;
      ex_result    = res;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      set_ex(1'b0, 5'd0, 1'b0, 1'b0, '0);
      mem_rdata = '0; hold = 1'b0; cnt_clr = 1'b0;
      id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
      #3;
      chk("rst_mem_rd", mem_rd, 0);
      chk("rst_mem_rw", mem_reg_write, 0);
      chk("rst_wb_data", wb_data, 0);
      chk("rst_rf_we", rf_we, 0);
      chk("rst_cnt", stall_cnt, 0);
      rst_n = 1'b1;

      // ADD rd=5 -> MEM next cycle, RF write the cycle after
      #3;
      set_ex(1'b1, 5'd5, 1'b1, 1'b0, 32'h0000_00AA);
      tick();
      chk("add_mem_rd", mem_rd, 5);
      chk("add_mem_res", mem_result, 32'hAA);
      chk("add_mem_rw", mem_reg_write, 1);
      chk("add_rf_we_early", rf_we, 0);
      set_ex(1'b0, 5'd0, 1'b0, 1'b0, 32'hDEAD_BEEF);
      tick();
      chk("add_rf_we", rf_we, 1);
      chk("add_rf_waddr", rf_waddr, 5);
      chk("add_rf_wdata", rf_wdata, 32'hAA);
      chk("bubble_mem_rw", mem_reg_write, 0);
      chk("bubble_mem_rd", mem_rd, 0);
      chk("isolate_mem_res", mem_result, 32'hAA);

      // load-use detection on rs2 only, then its disable
      set_ex(1'b1, 5'd9, 1'b1, 1'b1, '0);
      id_rs2 = 5'd9; id_use_rs2 = 1'b1;
      #1 chk("lus_rs2", load_use_stall, 1);
      id_use_rs2 = 1'b0;
      #1 chk("lus_rs2_unused", load_use_stall, 0);
      id_rs2 = '0;

      // LW rd=7 with dependent rs1 in ID
      set_ex(1'b1, 5'd7, 1'b1, 1'b1, 32'h0000_0100);
      id_rs1 = 5'd7; id_use_rs1 = 1'b1;
      #1 chk("lus_rs1", load_use_stall, 1);
      tick();
      chk("lw_cnt", stall_cnt, 1);
      set_ex(1'b0, 5'd0, 1'b0, 1'b0, '0);
      id_use_rs1 = 1'b0; id_rs1 = '0;
      mem_rdata = 32'h1234_5678;
      tick();
      chk("lw_wb_data", wb_data, 32'h1234_5678);
      chk("lw_rf_waddr", rf_waddr, 7);
      chk("lw_rf_we", rf_we, 1);

      // writes to x0 never reach the register file
      set_ex(1'b1, 5'd0, 1'b1, 1'b1, 32'h55);
      id_rs1 = 5'd0; id_use_rs1 = 1'b1;
      #1 chk("lus_x0", load_use_stall, 0);
      id_use_rs1 = 1'b0;
      set_ex(1'b1, 5'd0, 1'b1, 1'b0, 32'h77);
      tick();
      chk("x0_mem_rw", mem_reg_write, 0);
      set_ex(1'b0, 5'd0, 1'b0, 1'b0, '0);
      tick();
      chk("x0_rf_we", rf_we, 0);

      // hold freezes both stages and counts stall cycles
      cnt_clr = 1'b1;
      set_ex(1'b1, 5'd2, 1'b1, 1'b0, 32'h22);
      tick();
      cnt_clr = 1'b0;
      chk("clr_cnt", stall_cnt, 0);
      set_ex(1'b1, 5'd3, 1'b1, 1'b0, 32'h33);
      tick();
      set_ex(1'b1, 5'd4, 1'b1, 1'b0, 32'h44);
      hold = 1'b1;
      repeat (3) tick();
      chk("hold_mem_rd", mem_rd, 3);
      chk("hold_mem_res", mem_result, 32'h33);
      chk("hold_wb_rd", wb_rd, 2);
      chk("hold_wb_data", wb_data, 32'h22);
      chk("hold_cnt", stall_cnt, 3);
      hold = 1'b0;
      tick();
      chk("rel_mem_rd", mem_rd, 4);
      chk("rel_mem_res", mem_result, 32'h44);
      chk("rel_wb_rd", wb_rd, 3);
      chk("rel_wb_data", wb_data, 32'h33);
      chk("rel_cnt", stall_cnt, 3);

      // asynchronous reset between edges discards in-flight work
      set_ex(1'b0, 5'd0, 1'b0, 1'b0, '0);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_mem_rd", mem_rd, 0);
      chk("arst_mem_res", mem_result, 0);
      chk("arst_wb_rd", wb_rd, 0);
      chk("arst_wb_data", wb_data, 0);
      chk("arst_rf_we", rf_we, 0);
      chk("arst_cnt", stall_cnt, 0);
      rst_n = 1'b1;
      set_ex(1'b1, 5'd6, 1'b1, 1'b0, 32'h66);
      tick();
      chk("post_rst_mem_rd", mem_rd, 6);
      chk("post_rst_rf_we", rf_we, 0);
      set_ex(1'b0, 5'd0, 1'b0, 1'b0, '0);
      tick();
      chk("post_rst_wr", rf_we, 1);
      chk("post_rst_waddr", rf_waddr, 6);

      // counter saturation and clear priority
      hold = 1'b1;
      repeat (65534) @(posedge clk);
      #1 chk("cnt_fffe", stall_cnt, 16'hFFFE);
      repeat (3) tick();
      chk("cnt_sat", stall_cnt, 16'hFFFF);
      cnt_clr = 1'b1;
      tick();
      chk("cnt_clr_hold", stall_cnt, 0);
      cnt_clr = 1'b0;
      hold = 1'b0;

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/writeback_pipe.md
WRITEBACK_PIPE -- requirements
Module: writeback_pipe

Interface
REQ-001 Parameter XLEN, default 32, datapath width.
REQ-002 Parameter CNT_W, default 16, stall-counter width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 ex_valid  input  1  EX-stage instruction valid (0 = bubble).
REQ-006 ex_rd  input  5  EX destination register.
REQ-007 ex_reg_write  input  1  EX instruction writes rd.
REQ-008 ex_mem_read  input  1  EX instruction is a load.
REQ-009 ex_result  input  XLEN  EX ALU result / load address-independent result.
REQ-010 mem_rdata  input  XLEN  data-memory read data for the load currently in MEM.
REQ-011 hold  input  1  memory wait; freezes both stage registers.
REQ-012 id_rs1, id_rs2  input  5 each  ID-stage source registers.
REQ-013 id_use_rs1, id_use_rs2  input  1 each  ID instruction reads rs1/rs2.
REQ-014 cnt_clr  input  1  synchronous clear of stall_cnt.
REQ-015 mem_rd, mem_reg_write, mem_result  output  5/1/XLEN  MEM-stage bypass source.
REQ-016 wb_rd, wb_reg_write, wb_data  output  5/1/XLEN  WB-stage bypass source.
REQ-017 rf_we, rf_waddr, rf_wdata  output  1/5/XLEN  register-file write port.
REQ-018 load_use_stall  output  1  request to stall IF/ID and bubble EX.
REQ-019 stall_cnt  output  CNT_W  saturating stall-cycle counter.

Function
REQ-020 When hold=0, EX/MEM SHALL capture: mem_rd<=ex_rd, mem_reg_write<=ex_valid&ex_reg_write&(ex_rd!=0), mem_is_load<=ex_valid&ex_mem_read.
REQ-021 A bubble (ex_valid=0) SHALL produce mem_reg_write=0 and mem_rd=0.
REQ-022 mem_result SHALL load ex_result only when hold=0, ex_valid=1, ex_reg_write=1; otherwise retain its value (operand isolation).
REQ-023 When hold=0, MEM/WB SHALL capture wb_rd<=mem_rd, wb_reg_write<=mem_reg_write.
REQ-024 wb_data SHALL load (mem_is_load ? mem_rdata : mem_result) only when hold=0 and mem_reg_write=1; otherwise retain.
REQ-025 Latency: ex_* to mem_* one cycle; mem_* to wb_* one cycle; ex_* to rf write two cycles absent hold.
REQ-026 When hold=1, all stage registers SHALL retain their values; no bubble is inserted.
REQ-027 rf_we SHALL equal wb_reg_write (combinational), rf_waddr=wb_rd, rf_wdata=wb_data; repeated writes during hold are idempotent and permitted.
REQ-028 load_use_stall SHALL be combinational: ex_valid & ex_mem_read & ex_reg_write & (ex_rd!=0) & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
REQ-029 load_use_stall SHALL NOT stall this block; the load advances to MEM while upstream inserts a bubble, so the dependent instruction obtains the load value from WB.
REQ-030 stall_cnt SHALL increment by 1 each cycle (load_use_stall | hold) = 1, saturating at 2^CNT_W-1 without wrap.
REQ-031 cnt_clr=1 SHALL set stall_cnt to 0 next edge, taking priority over a simultaneous increment.
REQ-032 Register x0: no path SHALL assert mem_reg_write, wb_reg_write or rf_we for rd=0.

Reset
REQ-033 rst_n=0 SHALL immediately clear all registered outputs (mem_*, wb_*, mem_is_load, stall_cnt) to 0, independent of clk.
REQ-034 Reset asserted mid-operation SHALL discard in-flight instructions; no rf write occurs until an instruction enters after rst_n=1.
REQ-035 First edge after rst_n deassertion SHALL behave as a normal capture.

Structure
REQ-036 XLEN default, register-address width 5 and CNT_W default SHALL live in the shared core package.
REQ-037 One sub-module, pipe_stage_reg (enable-gated, async active-low clear, width-parameterized), SHALL be instantiated for EX/MEM and MEM/WB.

Verification
REQ-038 ADD rd=5 result 0x0000_00AA, hold=0 -> cycle+1 mem_rd=5/mem_result=0xAA; cycle+2 rf_we=1, rf_waddr=5, rf_wdata=0xAA.
REQ-039 LW rd=7 in EX, ID rs1=7 use_rs1=1 -> load_use_stall=1 same cycle; mem_rdata=0x1234_5678 next cycle -> wb_data=0x1234_5678 following cycle.
REQ-040 ADD rd=0, ex_valid=1 -> mem_reg_write=0, rf_we never 1; load_use_stall=0 for LW rd=0.
REQ-041 hold=1 for 3 cycles with ADD in MEM -> mem_*/wb_* unchanged, stall_cnt +3; release -> advance by one stage.
REQ-042 Preload stall_cnt to 0xFFFE, hold 3 cycles -> saturates 0xFFFF; cnt_clr with hold=1 -> 0.
REQ-043 rst_n=0 asynchronously between edges with valid entries -> all outputs 0 before next edge; rf_we=0 after release until new instruction arrives.
